// File: rtl/apb_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : apb_irq_ctrl
// Brief    : APB interrupt controller with per-source level/edge capture,
//            masking, fixed-priority claim and a registered CPU interrupt.
// Revision : 1.0 - initial N-source release
// ============================================================================
module apb_irq_ctrl #(
   parameter  int NUM_IRQ = 16,
   localparam int ID_W    = $clog2(NUM_IRQ)
) (
   input  logic               pclk_i,
   input  logic               rst_i,
   input  logic               psel_i,
   input  logic               penable_i,
   input  logic               pwrite_i,
   input  logic [31:0]        paddr_i,
   input  logic [31:0]        pwdata_i,
   output logic [31:0]        prdata_o,
   output logic               pready_o,
   output logic               pslverr_o,
   input  logic               enable_i,
   input  logic [NUM_IRQ-1:0] irq_i,
   output logic               interrupt_o,
   output logic [ID_W-1:0]    irq_id_o
);

   localparam logic [7:0]         VERSION  = 8'h02;
   localparam logic [31:0]        ID_VALUE = {16'h0000, 8'(NUM_IRQ), VERSION};
   localparam logic [NUM_IRQ-1:0] ONE_HOT0 = NUM_IRQ'(1);

   logic [NUM_IRQ-1:0] status;
   logic [NUM_IRQ-1:0] mask;
   logic [NUM_IRQ-1:0] mode;
   logic [NUM_IRQ-1:0] irq_prev;
   logic [NUM_IRQ-1:0] pending;
   logic [NUM_IRQ-1:0] rise;
   logic [NUM_IRQ-1:0] clr;
   logic [NUM_IRQ-1:0] next_status;
   logic [ID_W-1:0]    enc_id;
   logic               any_pend;
   logic               access;
   logic               wr_en;
   logic               rd_setup;
   logic               claim_acc;
   logic [31:0]        rd_data;
   logic               unused_wdata;

   assign pready_o  = 1'b1;
   assign access    = psel_i & penable_i;
   assign pslverr_o = access & ((paddr_i > 32'd5) |
                      (pwrite_i & ((paddr_i == 32'd0) | (paddr_i == 32'd4) | (paddr_i == 32'd5))));
   assign wr_en     = access & pwrite_i & ~pslverr_o;
   assign rd_setup  = psel_i & ~penable_i & ~pwrite_i;
   assign claim_acc = access & ~pwrite_i & (paddr_i == 32'd4);

   assign unused_wdata = ^pwdata_i[31:NUM_IRQ];

   assign pending  = status & mask;
   assign any_pend = |pending;

   // Scan from the top so the lowest pending index is the last one written.
   always_comb begin
      enc_id = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (pending[i]) begin
            enc_id = ID_W'(i);
         end
      end
   end

   // The claim clears the ID latched into prdata_o at setup, not the live winner.
   always_comb begin
      clr = '0;
      if (wr_en && (paddr_i == 32'd1)) begin
         clr = pwdata_i[NUM_IRQ-1:0];
      end
      if (claim_acc && prdata_o[31]) begin
         clr = clr | (ONE_HOT0 << prdata_o[ID_W-1:0]);
      end
   end

   assign rise        = irq_i & ~irq_prev;
   assign next_status = (mode & ((status & ~clr) | rise)) | (~mode & irq_i);

   always_comb begin
      rd_data = '0;
      case (paddr_i)
         32'd0:   rd_data = {{(32 - NUM_IRQ){1'b0}}, status};
         32'd2:   rd_data = {{(32 - NUM_IRQ){1'b0}}, mask};
         32'd3:   rd_data = {{(32 - NUM_IRQ){1'b0}}, mode};
         32'd4:   rd_data = {any_pend, {(31 - ID_W){1'b0}}, enc_id};
         32'd5:   rd_data = ID_VALUE;
         default: rd_data = '0;
      endcase
   end

   always_ff @(posedge pclk_i) begin
      if (rst_i) begin
         status      <= '0;
         mask        <= '0;
         mode        <= '0;
         irq_prev    <= '0;
         prdata_o    <= '0;
         interrupt_o <= 1'b0;
         irq_id_o    <= '0;
      end else begin
         irq_prev    <= irq_i;
         status      <= next_status;
         interrupt_o <= enable_i & any_pend;
         irq_id_o    <= enc_id;
         if (rd_setup) begin
            prdata_o <= rd_data;
         end
         if (wr_en && (paddr_i == 32'd2)) begin
            mask <= pwdata_i[NUM_IRQ-1:0];
         end
         if (wr_en && (paddr_i == 32'd3)) begin
            mode <= pwdata_i[NUM_IRQ-1:0];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_apb_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_irq_ctrl
// Brief    : Directed scenarios plus randomized traffic against a cycle model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_irq_ctrl;

   localparam int N = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [31:0]   paddr = '0, pwdata = '0;
   logic [31:0]   prdata;
   logic          pready, pslverr;
   logic          enable = 1'b1;
   logic [N-1:0]  irq = '0;
   logic          interrupt;
   logic [3:0]    irq_id;

   int n_vec = 0;
   int n_err = 0;

   apb_irq_ctrl #(.NUM_IRQ(N)) dut (
      .pclk_i(clk), .rst_i(rst), .psel_i(psel), .penable_i(penable),
      .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata),
      .pready_o(pready), .pslverr_o(pslverr), .enable_i(enable), .irq_i(irq),
      .interrupt_o(interrupt), .irq_id_o(irq_id)
   );

   always #5 clk = ~clk;

   // Reference model: register-map behaviour evaluated once per clock.
   logic [N-1:0] m_status = '0, m_mask = '0, m_mode = '0, m_prev = '0;
   logic [31:0]  m_prdata = '0;
   logic         m_int = 1'b0;
   logic [3:0]   m_id = '0;

   function automatic int lowest(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic logic exp_err(input logic s, e, w, input logic [31:0] a);
      return s && e && (a > 5 || (w && (a == 0 || a == 4 || a == 5)));
   endfunction

   always @(posedge clk) begin
      int           win;
      logic         acc, bad;
      logic [N-1:0] clr, nxt;
      if (rst) begin
         m_status = '0; m_mask = '0; m_mode = '0; m_prev = '0;
         m_prdata = '0; m_int = 1'b0; m_id = '0;
      end else begin
         win = lowest(m_status & m_mask);
         acc = psel && penable;
         bad = exp_err(psel, penable, pwrite, paddr);
         clr = '0;
         if (acc && pwrite && !bad && paddr == 1) clr = pwdata[N-1:0];
         if (acc && !pwrite && paddr == 4 && m_prdata[31]) clr[m_prdata[3:0]] = 1'b1;
         for (int i = 0; i < N; i++)
            nxt[i] = m_mode[i] ? ((m_status[i] && !clr[i]) || (irq[i] && !m_prev[i])) : irq[i];
         m_int = enable && (win >= 0);
         m_id  = (win >= 0) ? 4'(win) : 4'd0;
         if (psel && !penable && !pwrite) begin
            case (paddr)
               0: m_prdata = 32'(m_status);
               2: m_prdata = 32'(m_mask);
               3: m_prdata = 32'(m_mode);
               4: m_prdata = (win >= 0) ? (32'h8000_0000 | 32'(win)) : 32'd0;
               5: m_prdata = 32'h0000_1002;
               default: m_prdata = 32'd0;
            endcase
         end
         if (acc && pwrite && !bad && paddr == 2) m_mask = pwdata[N-1:0];
         if (acc && pwrite && !bad && paddr == 3) m_mode = pwdata[N-1:0];
         m_status = nxt;
         m_prev   = irq;
      end
   end

   task automatic apb_write(input logic [31:0] a, d, output logic err);
      @(negedge clk); psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
      @(negedge clk); penable = 1; #1 err = pslverr;
      @(negedge clk); psel = 0; penable = 0; pwrite = 0;
   endtask

   task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic err);
      @(negedge clk); psel = 1; penable = 0; pwrite = 0; paddr = a;
      @(negedge clk); penable = 1; #1 d = prdata; err = pslverr;
      @(negedge clk); psel = 0; penable = 0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      logic        e;
      logic [31:0] exp_vals [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1002};
      rst = 1;
      repeat (3) @(negedge clk);
      rst = 0;
      for (int a = 0; a < 6; a++) begin
         apb_read(32'(a), d, e);
         n_vec++;
         if (d !== exp_vals[a] || e !== 1'b0) begin
            n_err++;
            $display("FAIL reset_read[%0d]: got %h err %b, expected %h err 0", a, d, e, exp_vals[a]);
         end
      end
      n_vec++;
      if (interrupt !== 1'b0 || irq_id !== 4'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got int %b id %0d, expected 0 0", interrupt, irq_id);
      end
   endtask

   task automatic test_level();
      logic [31:0] d;
      logic        e;
      apb_write(2, 32'h4, e);
      irq[2] = 1;
      @(negedge clk);
      n_vec++;
      if (interrupt !== 1'b0) begin n_err++; $display("FAIL level_early: got %b expected 0", interrupt); end
      @(negedge clk);
      n_vec++;
      if (interrupt !== 1'b1) begin n_err++; $display("FAIL level_rise: got %b expected 1", interrupt); end
      apb_write(1, 32'h4, e);
      apb_read(0, d, e);
      n_vec++;
      if (d !== 32'h4 || interrupt !== 1'b1) begin
         n_err++;
         $display("FAIL level_clear_ignored: got status %h int %b, expected 4 1", d, interrupt);
      end
      irq[2] = 0;
      @(negedge clk);
      n_vec++;
      if (interrupt !== 1'b1) begin n_err++; $display("FAIL level_fall_early: got %b expected 1", interrupt); end
      @(negedge clk);
      n_vec++;
      if (interrupt !== 1'b0) begin n_err++; $display("FAIL level_fall: got %b expected 0", interrupt); end
   endtask

   task automatic test_edge_claim();
      logic [31:0] d;
      logic        e;
      logic [31:0] exp_claims [3] = '{32'h8000_0005, 32'h8000_0009, 32'h0};
      apb_write(3, 32'hFFFF, e);
      apb_write(2, 32'hFFFF, e);
      irq[5] = 1; irq[9] = 1;
      @(negedge clk); irq[5] = 0; irq[9] = 0;
      @(negedge clk);
      n_vec++;
      if (irq_id !== 4'd5) begin n_err++; $display("FAIL edge_id: got %0d expected 5", irq_id); end
      apb_read(0, d, e);
      n_vec++;
      if (d !== 32'h0220) begin n_err++; $display("FAIL edge_status: got %h expected 0220", d); end
      for (int k = 0; k < 3; k++) begin
         apb_read(4, d, e);
         n_vec++;
         if (d !== exp_claims[k]) begin
            n_err++;
            $display("FAIL claim[%0d]: got %h expected %h", k, d, exp_claims[k]);
         end
         if (k == 0) begin
            apb_read(0, d, e);
            n_vec++;
            if (d !== 32'h0200) begin n_err++; $display("FAIL claim_status: got %h expected 0200", d); end
         end
      end
      n_vec++;
      if (interrupt !== 1'b0) begin n_err++; $display("FAIL claim_int: got %b expected 0", interrupt); end
   endtask

   task automatic test_clear_collision();
      logic [31:0] d;
      logic        e;
      irq[3] = 1;
      @(negedge clk); irq[3] = 0;
      @(negedge clk); psel = 1; penable = 0; pwrite = 1; paddr = 1; pwdata = 32'h8;
      @(negedge clk); penable = 1; irq[3] = 1;
      @(negedge clk); psel = 0; penable = 0; pwrite = 0; irq[3] = 0;
      apb_read(0, d, e);
      n_vec++;
      if (d !== 32'h8) begin n_err++; $display("FAIL collision_keep: got %h expected 8", d); end
      apb_write(1, 32'h8, e);
      apb_read(0, d, e);
      n_vec++;
      if (d !== 32'h0) begin n_err++; $display("FAIL collision_clear: got %h expected 0", d); end
   endtask

   task automatic test_enable();
      logic [31:0] d;
      logic        e;
      enable = 0;
      irq[7] = 1;
      @(negedge clk); irq[7] = 0;
      repeat (3) @(negedge clk);
      n_vec++;
      if (interrupt !== 1'b0 || irq_id !== 4'd7) begin
         n_err++;
         $display("FAIL enable_low: got int %b id %0d, expected 0 7", interrupt, irq_id);
      end
      enable = 1;
      @(negedge clk);
      n_vec++;
      if (interrupt !== 1'b1) begin n_err++; $display("FAIL enable_high: got %b expected 1", interrupt); end
      apb_read(4, d, e);
      n_vec++;
      if (d !== 32'h8000_0007) begin n_err++; $display("FAIL enable_claim: got %h expected 80000007", d); end
      repeat (2) @(negedge clk);
      n_vec++;
      if (interrupt !== 1'b0) begin n_err++; $display("FAIL enable_drop: got %b expected 0", interrupt); end
   endtask

   task automatic test_errors();
      logic [31:0] d;
      logic        e;
      logic [31:0] bad_addrs [4] = '{32'd0, 32'd7, 32'd4, 32'd5};
      for (int k = 0; k < 4; k++) begin
         apb_write(bad_addrs[k], 32'h0, e);
         n_vec++;
         if (e !== 1'b1) begin n_err++; $display("FAIL err_write[%0d]: got %b expected 1", bad_addrs[k], e); end
      end
      apb_read(2, d, e);
      n_vec++;
      if (d !== 32'hFFFF || e !== 1'b0) begin n_err++; $display("FAIL err_mask: got %h err %b expected ffff 0", d, e); end
      apb_read(3, d, e);
      n_vec++;
      if (d !== 32'hFFFF) begin n_err++; $display("FAIL err_mode: got %h expected ffff", d); end
      apb_read(9, d, e);
      n_vec++;
      if (d !== 32'h0 || e !== 1'b1) begin n_err++; $display("FAIL err_read9: got %h err %b expected 0 1", d, e); end
      apb_read(1, d, e);
      n_vec++;
      if (d !== 32'h0 || e !== 1'b0) begin n_err++; $display("FAIL read_clear: got %h err %b expected 0 0", d, e); end
      @(negedge clk); psel = 0; penable = 1; pwrite = 1; paddr = 7;
      #1;
      n_vec++;
      if (pslverr !== 1'b0) begin n_err++; $display("FAIL err_nosel: got %b expected 0", pslverr); end
      @(negedge clk); penable = 0; pwrite = 0; paddr = 0;
   endtask

   task automatic test_random();
      int   phase = 0;
      logic start;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         n_vec++;
         if (interrupt !== m_int || irq_id !== m_id || prdata !== m_prdata) begin
            n_err++;
            $display("FAIL random[%0d]: got int %b id %0d rd %h, expected %b %0d %h",
                     c, interrupt, irq_id, prdata, m_int, m_id, m_prdata);
         end
         rst    = ($urandom_range(0, 149) == 0);
         irq    = irq ^ N'($urandom & $urandom & $urandom);
         enable = ($urandom_range(0, 7) != 0);
         start  = 1'b0;
         if (phase == 1) begin
            penable = 1; phase = 2;
         end else begin
            start = ($urandom_range(0, 2) != 0);
         end
         if (start) begin
            psel = 1; penable = 0; pwrite = $urandom_range(0, 1) == 1;
            paddr = ($urandom_range(0, 3) == 0) ? 32'd4 : 32'($urandom_range(0, 7));
            pwdata = $urandom; phase = 1;
         end else if (phase != 2 || penable == 0) begin
            psel = 0; penable = 0; phase = 0;
         end else begin
            psel = 0; penable = 0; phase = 0;
         end
         #1;
         n_vec++;
         if (pslverr !== exp_err(psel, penable, pwrite, paddr)) begin
            n_err++;
            $display("FAIL random_err[%0d]: got %b expected %b", c, pslverr, exp_err(psel, penable, pwrite, paddr));
         end
      end
      @(negedge clk); psel = 0; penable = 0; pwrite = 0; rst = 0;
   endtask

   initial begin
      test_reset();
      test_level();
      test_edge_claim();
      test_clear_collision();
      test_enable();
      test_errors();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/apb_irq_ctrl.md
# apb_irq_ctrl

Parametrised APB interrupt controller, the N-source successor of the 4-source status/clear/mask controller. Collects `NUM_IRQ` interrupt sources, each individually configurable as level or rising-edge, masks them and drives one registered interrupt line to the CPU. Adds a fixed-priority claim register that returns the winning source ID and auto-clears edge sources. Sits on the peripheral APB bus next to the other slaves.

## Interface
- `NUM_IRQ`, 16, number of sources, 2..31; `ID_W` = $clog2(NUM_IRQ), derived and not overridable
- `pclk_i` in 1: single clock for all logic
- `rst_i` in 1: synchronous, active-high reset
- `psel_i`, `penable_i`, `pwrite_i` in 1: APB control
- `paddr_i` in 32: word-index address, raw values 0..5
- `pwdata_i` in 32: write data; bits above `NUM_IRQ-1` ignored
- `prdata_o` out 32: registered read data
- `pready_o` out 1: tied 1, no wait states
- `pslverr_o` out 1: error flag in the access phase
- `enable_i` in 1: global output enable
- `irq_i` in NUM_IRQ: raw sources, already synchronous to `pclk_i`
- `interrupt_o` out 1: registered CPU interrupt
- `irq_id_o` out ID_W: registered ID of the highest-priority masked pending source

## Operation
- Register map:
  - 0 STATUS: RO pending bits.
  - 1 CLEAR: WO write-1-to-clear; reads 0.
  - 2 MASK: RW, 1 = enabled.
  - 3 MODE: RW, 1 = rising edge, 0 = level.
  - 4 CLAIM: RO. Bit31 = any masked pending; [ID_W-1:0] = winning ID.
  - 5 ID: RO, parameter readback. {NUM_IRQ[7:0] in [15:8], version 8'h02 in [7:0]}.
- Unused register bits read 0.
- Write strobe: `psel_i & penable_i & pwrite_i`. Read capture: `psel_i & ~penable_i & ~pwrite_i` (setup phase), loading `prdata_o`.
- `pslverr_o` = `psel_i & penable_i & (addr > 5 | write to 0, 4 or 5)`.
  - Erroring writes have no effect.
  - Reads of unmapped addresses load `prdata_o` = 0.
- Edge detect: `irq_prev` register, updated every cycle. Set condition per bit is `irq_i & ~irq_prev` (edge mode) or `irq_i` (level mode).
- Status update per bit, every cycle:
  - Level mode: `status <= irq_i`. CLEAR and claim have no effect.
  - Edge mode: `status <= (status & ~clr) | rise`. `clr` = CLEAR write bit or claim-clear.
  - A set in the same cycle as a clear wins: the new event is kept.
- Priority: lowest index of `status & mask` wins. A combinational priority encoder feeds `irq_id_o`, CLAIM and `interrupt_o`.
- Claim:
  - The setup phase of a CLAIM read latches {valid, id} into `prdata_o`.
  - On the access-phase edge, if the latched valid is 1 and that source is in edge mode, its status bit is cleared.
  - Status changes between setup and access do not alter the cleared ID.
- Output: `interrupt_o <= enable_i & |(status & mask)`.
  - `irq_id_o` updates every cycle from the encoder, independent of `enable_i`.
  - It is 0 when nothing is pending.
- `enable_i` low does not stop capture, status or APB access.
- Changing MODE leaves the status bit unchanged. Its subsequent update follows the new mode.

## Timing
- Reset values: `prdata_o`, `interrupt_o`, `irq_id_o`, status, mask, mode and `irq_prev` are all 0.
- `pslverr_o` is combinational; it is 0 whenever `psel_i` is low.
- `irq_prev` resets to 0. An edge-mode source held high through reset release therefore registers one edge at the first active cycle.
- `rst_i` has priority over every APB access in progress. A transfer spanning reset returns 0 and has no side effect.
- Source to output latency:
  - `irq_i` sampled high at edge N sets status after N.
  - `interrupt_o` and `irq_id_o` are valid after edge N+1.
- Clear/claim at edge M: status drops after M, `interrupt_o` drops after M+1 (if no other masked source is pending).
- MASK write at edge M affects `interrupt_o` after M+1.
- Read data is valid during the access phase, i.e. one cycle after the setup-phase capture.
- A read of CLEAR returns 0; a read of any other register returns its value at the setup-phase edge.

## Test plan
- Reset, then read all six addresses:
  - STATUS, MASK, MODE and CLAIM read 0.
  - ID reads 0x1002 (NUM_IRQ=16).
  - `interrupt_o`=0 and `pslverr_o`=0.
- Level mode, MASK=0x0004, `irq_i[2]` driven high:
  - `interrupt_o`=1 two edges later.
  - A CLEAR write of 0x4 has no effect.
  - Driving `irq_i[2]` low drops `interrupt_o` two edges later.
- Edge mode, MODE=MASK=0xFFFF, 1-cycle pulse on `irq_i[5]` and on `irq_i[9]`:
  - STATUS=0x0220 and `irq_id_o`=5.
  - CLAIM read returns 0x80000005, then STATUS=0x0200.
  - Next CLAIM returns 0x80000009.
  - Third CLAIM returns 0 and `interrupt_o`=0.
- Edge source 3: CLEAR write of 0x8 in the same cycle as a new rising edge on `irq_i[3]` -> STATUS bit 3 stays 1.
- Pending masked source with `enable_i`=0:
  - `interrupt_o`=0, and `irq_id_o` still shows the ID.
  - Raising `enable_i` sets `interrupt_o` one edge later.
- Error cases:
  - Write to address 0 or 7 -> `pslverr_o`=1 in the access phase, registers unchanged.
  - Read of address 9 -> `prdata_o`=0, `pslverr_o`=1.
